alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width; legal range 8..64.
REQ-002 Parameter FLAG_RST, default 4'b0000: reset value of {V,Z,N,C}.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op  input  4  operation code, decoded per the package table.
REQ-008 a, b  input  WIDTH each  first (Rdst) and second (Rsrc) operands.
REQ-009 out_valid  output  1  result and flags are valid.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 result_lo, result_hi  output  WIDTH each  primary result; upper product or remainder (zero for other ops).
REQ-012 flags  output  4  registered {V,Z,N,C}.

Function
REQ-013 Opcodes SHALL be: 0 NOP, 1 NOT, 2 PASSA, 3 PASSB, 4 INC, 5 DEC, 6 ADD, 7 SUB (a-b), 8 AND, 9 OR, 10 SHL, 11 SHR, 12 SETC, 13 CLRC, 14 MUL, 15 DIV.
REQ-014 FSM states IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 IDLE & in_valid: latch op/a/b; ops 0-13 and DIV-by-zero go to DONE; MUL/DIV go to BUSY with iteration counter = WIDTH.
REQ-016 BUSY: one shift-add (MUL, unsigned) or one restoring-divide step (DIV, unsigned) per cycle; counter reaching 0 → DONE; BUSY lasts exactly WIDTH cycles.
REQ-017 Latency: out_valid asserted 1 cycle after accept for ops 0-13 and DIV-by-zero, WIDTH+1 cycles for MUL/DIV.
REQ-018 DONE holds result_lo/hi/flags stable until out_ready; DONE & out_ready → IDLE; in_valid ignored outside IDLE.
REQ-019 flags SHALL update only on entry to DONE, and only bits defined per op; others hold.
REQ-020 ADD/SUB/INC/DEC: update V,Z,N,C; C = carry-out (ADD/INC) or borrow, i.e. unsigned a<b (SUB) / a==0 (DEC); V = true signed overflow (SUB uses ~b).
REQ-021 NOT/AND/OR: update Z,N; clear C,V.
REQ-022 SHL/SHR: shift amount = b (unsigned); 0 → result a, C=0; 1..WIDTH-1 → C = last bit shifted out; ≥WIDTH → result 0, C=0; Z,N updated; V cleared.
REQ-023 PASSA/PASSB/NOP: result a / b / 0; no flag change.
REQ-024 SETC/CLRC: result 0; C set/cleared; V,Z,N hold.
REQ-025 MUL: {hi,lo}=a*b full 2·WIDTH bits; Z = product==0; N = hi MSB; C=V=(hi!=0).
REQ-026 DIV: lo=quotient, hi=remainder; Z = quotient==0; N=0; C=0; V=0.
REQ-027 DIV with b==0: lo all-ones, hi=a, V=1, Z=0, N=0, C=0.
REQ-028 All arithmetic SHALL be WIDTH-exact with wrap-around; no X on outputs for any op.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, counter 0, result_lo/hi 0, flags FLAG_RST, out_valid 0; in_ready 1 after release.
REQ-030 Reset asserted during BUSY or DONE SHALL abort the operation with no partial result emitted.

Structure
REQ-031 Opcode enum, flag bit indices (V=3,Z=2,N=1,C=0) and FSM state type SHALL live in shared package alu_pkg.
REQ-032 The iterative MUL/DIV datapath SHALL be one sub-module alu_muldiv_iter (start, done, WIDTH-parametrised); single-cycle ops stay in alu_mc.

Verification (WIDTH=16)
REQ-033 ADD a=16'h7FFF b=1 → result_lo 16'h8000, V=1 N=1 Z=0 C=0, out_valid one cycle after accept.
REQ-034 SUB a=3 b=5 → result_lo 16'hFFFE, C=1 N=1 V=0; then SHL a=16'h8001 b=1 → 16'h0002, C=1.
REQ-035 MUL a=16'hFFFF b=16'hFFFF → hi 16'hFFFE, lo 16'h0001, C=V=1, out_valid exactly 17 cycles after accept.
REQ-036 DIV a=100 b=7 → lo 14, hi 2 after 17 cycles; DIV a=9 b=0 → lo 16'hFFFF, hi 9, V=1 after 1 cycle.
REQ-037 Hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0, new in_valid ignored; then out_ready=1 → IDLE next cycle.
REQ-038 Assert rst_n=0 mid-MUL (cycle 8) → out_valid 0, flags FLAG_RST, in_ready 1 after release; next ADD 2+2 → 4.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode table, flag bit positions, FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_NOT   = 4'd1,
    OP_PASSA = 4'd2,
    OP_PASSB = 4'd3,
    OP_INC   = 4'd4,
    OP_DEC   = 4'd5,
    OP_ADD   = 4'd6,
    OP_SUB   = 4'd7,
    OP_AND   = 4'd8,
    OP_OR    = 4'd9,
    OP_SHL   = 4'd10,
    OP_SHR   = 4'd11,
    OP_SETC  = 4'd12,
    OP_CLRC  = 4'd13,
    OP_MUL   = 4'd14,
    OP_DIV   = 4'd15
  } aluOp_t;

  localparam int FLAG_V = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } aluState_t;

  // Divide-by-zero completes immediately, so only real MUL/DIV work iterates.
  function automatic logic needsIter(aluOp_t o, logic bIsZero);
    return (o == OP_MUL) || ((o == OP_DIV) && !bIsZero);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide, one step per cycle.
module alu_muldiv_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             isDiv,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] stepLo,
  output logic [WIDTH-1:0] stepHi
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] accHi, accLo, opB;
  logic [CW-1:0]    cnt;
  logic             busy;

  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic             divGe;

  // MUL: accHi accumulates, accLo holds the multiplier and collects low product bits.
  // DIV: accHi is the partial remainder, accLo shifts out dividend bits and in quotient bits.
  assign mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : '0);
  assign divShift = {accHi, accLo[WIDTH-1]};
  assign divGe    = (divShift >= {1'b0, opB});

  always_comb begin
    stepLo = '0;
    stepHi = '0;
    if (isDiv) begin
      stepHi = divGe ? (divShift[WIDTH-1:0] - opB) : divShift[WIDTH-1:0];
      stepLo = {accLo[WIDTH-2:0], divGe};
    end else begin
      stepHi = mulSum[WIDTH:1];
      stepLo = {mulSum[0], accLo[WIDTH-1:1]};
    end
  end

  // Valid during the final BUSY cycle; stepLo/stepHi then carry the finished result.
  assign done = busy && (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accHi <= '0;
      accLo <= '0;
      opB   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      accHi <= '0;
      accLo <= a;
      opB   <= b;
      cnt   <= CW'(WIDTH);
      busy  <= 1'b1;
    end else if (busy) begin
      accHi <= stepHi;
      accLo <= stepLo;
      cnt   <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops computed here, MUL/DIV delegated to alu_muldiv_iter.
module alu_mc
  import alu_pkg::*;
#(
  parameter int         WIDTH    = 16,
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output aluState_t        dbgState
);

  localparam int               MSB   = WIDTH - 1;
  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

  aluState_t state;
  aluOp_t    opIn, opReg;

  logic             iterStart, mdDone;
  logic [WIDTH-1:0] mdLo, mdHi;
  logic [WIDTH:0]   addSum, incSum, shlExt, shrExt;
  logic [WIDTH-1:0] subDiff, decDiff;
  logic             shiftBig, updZN;
  logic [WIDTH-1:0] sLo, sHi;
  logic [3:0]       sFlags, doneFlags;

  // Handshake: a request transfers on a rising edge with in_valid && in_ready; a
  // result transfers with out_valid && out_ready. Both readies/valids come from state only.
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign dbgState  = state;

  assign opIn      = aluOp_t'(op);
  assign iterStart = in_ready && in_valid && needsIter(opIn, (b == '0));

  assign addSum   = {1'b0, a} + {1'b0, b};
  assign incSum   = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
  assign subDiff  = a - b;
  assign decDiff  = a - {{(WIDTH-1){1'b0}}, 1'b1};
  assign shlExt   = {1'b0, a} << b;
  assign shrExt   = {a, 1'b0} >> b;
  assign shiftBig = (b >= W_VAL);

  always_comb begin
    sLo    = '0;
    sHi    = '0;
    sFlags = flags;
    updZN  = 1'b0;
    case (opIn)
      OP_NOT:   begin sLo = ~a; updZN = 1'b1; sFlags[FLAG_C] = 1'b0; sFlags[FLAG_V] = 1'b0; end
      OP_PASSA: sLo = a;
      OP_PASSB: sLo = b;
      OP_INC: begin
        sLo = incSum[MSB:0]; updZN = 1'b1;
        sFlags[FLAG_C] = incSum[WIDTH];
        sFlags[FLAG_V] = ~a[MSB] & incSum[MSB];
      end
      OP_DEC: begin
        sLo = decDiff; updZN = 1'b1;
        sFlags[FLAG_C] = (a == '0);
        sFlags[FLAG_V] = a[MSB] & ~decDiff[MSB];
      end
      OP_ADD: begin
        sLo = addSum[MSB:0]; updZN = 1'b1;
        sFlags[FLAG_C] = addSum[WIDTH];
        sFlags[FLAG_V] = (a[MSB] == b[MSB]) && (addSum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        sLo = subDiff; updZN = 1'b1;
        sFlags[FLAG_C] = (a < b);
        sFlags[FLAG_V] = (a[MSB] != b[MSB]) && (subDiff[MSB] != a[MSB]);
      end
      OP_AND:   begin sLo = a & b; updZN = 1'b1; sFlags[FLAG_C] = 1'b0; sFlags[FLAG_V] = 1'b0; end
      OP_OR:    begin sLo = a | b; updZN = 1'b1; sFlags[FLAG_C] = 1'b0; sFlags[FLAG_V] = 1'b0; end
      // Shift amounts of WIDTH or more flush everything, including the carry.
      OP_SHL: begin
        sLo = shiftBig ? '0 : shlExt[MSB:0]; updZN = 1'b1;
        sFlags[FLAG_C] = shiftBig ? 1'b0 : shlExt[WIDTH];
        sFlags[FLAG_V] = 1'b0;
      end
      OP_SHR: begin
        sLo = shiftBig ? '0 : shrExt[WIDTH:1]; updZN = 1'b1;
        sFlags[FLAG_C] = shiftBig ? 1'b0 : shrExt[0];
        sFlags[FLAG_V] = 1'b0;
      end
      OP_SETC:  sFlags[FLAG_C] = 1'b1;
      OP_CLRC:  sFlags[FLAG_C] = 1'b0;
      OP_DIV: begin
        if (b == '0) begin
          sLo    = '1;
          sHi    = a;
          sFlags = 4'b0000;
          sFlags[FLAG_V] = 1'b1;
        end
      end
      default: ;
    endcase
    if (updZN) begin
      sFlags[FLAG_Z] = (sLo == '0);
      sFlags[FLAG_N] = sLo[MSB];
    end
  end

  always_comb begin
    doneFlags = 4'b0000;
    if (opReg == OP_MUL) begin
      doneFlags[FLAG_Z] = ({mdHi, mdLo} == '0);
      doneFlags[FLAG_N] = mdHi[MSB];
      doneFlags[FLAG_C] = (mdHi != '0);
      doneFlags[FLAG_V] = (mdHi != '0);
    end else begin
      doneFlags[FLAG_Z] = (mdLo == '0);
    end
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) uIter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (iterStart),
    .isDiv  (opReg == OP_DIV),
    .a      (a),
    .b      (b),
    .done   (mdDone),
    .stepLo (mdLo),
    .stepHi (mdHi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      opReg     <= OP_NOP;
      result_lo <= '0;
      result_hi <= '0;
      flags     <= FLAG_RST;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            opReg <= opIn;
            if (needsIter(opIn, (b == '0))) begin
              state <= ST_BUSY;
            end else begin
              state     <= ST_DONE;
              result_lo <= sLo;
              result_hi <= sHi;
              flags     <= sFlags;
            end
          end
        end
        ST_BUSY: begin
          if (mdDone) begin
            state     <= ST_DONE;
            result_lo <= mdLo;
            result_hi <= mdHi;
            flags     <= doneFlags;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=16): directed vectors, randomized ops vs. a reference model.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int         W           = 16;
  localparam logic [3:0] TB_FLAG_RST = 4'b1010;
  localparam int         SB_W        = 4 + 2*W + 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   in_op;
  logic [W-1:0] in_a, in_b, result_lo, result_hi;
  logic [3:0]   flags;
  aluState_t    dbg_state;

  int test_cnt = 0;
  int fail_cnt = 0;
  logic [3:0]      model_flags;
  logic [SB_W-1:0] exp_q[$];
  logic [W-1:0]    obs_lo, obs_hi;
  logic [3:0]      obs_flags;
  int              obs_lat;

  alu_mc #(.WIDTH(W), .FLAG_RST(TB_FLAG_RST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (in_op),
    .a         (in_a),
    .b         (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .flags     (flags),
    .dbgState  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // reference model: plain integer arithmetic over the opcode rules
  function automatic void ref_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [3:0] fin, output logic [W-1:0] lo,
                                    output logic [W-1:0] hi, output logic [3:0] fo);
    longint ua, ub, sa, sb, r;
    logic v, z, n, c, setzn;
    v = fin[3]; z = fin[2]; n = fin[1]; c = fin[0];
    lo = '0; hi = '0; setzn = 1'b0;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b); r = 0;
    case (op)
      4'd1: begin lo = ~a; c = 0; v = 0; setzn = 1; end
      4'd2: lo = a;
      4'd3: lo = b;
      4'd4: begin r = ua + 1; lo = r[W-1:0]; c = (r > 65535); v = (sa + 1 > 32767); setzn = 1; end
      4'd5: begin r = ua - 1; lo = r[W-1:0]; c = (ua == 0); v = (sa - 1 < -32768); setzn = 1; end
      4'd6: begin r = ua + ub; lo = r[W-1:0]; c = (r > 65535);
                  v = (sa + sb > 32767) || (sa + sb < -32768); setzn = 1; end
      4'd7: begin r = ua - ub; lo = r[W-1:0]; c = (ua < ub);
                  v = (sa - sb > 32767) || (sa - sb < -32768); setzn = 1; end
      4'd8: begin lo = a & b; c = 0; v = 0; setzn = 1; end
      4'd9: begin lo = a | b; c = 0; v = 0; setzn = 1; end
      4'd10: begin
        if (ub >= W) begin lo = '0; c = 0; end
        else begin r = ua << ub; lo = r[W-1:0]; c = r[W]; end
        v = 0; setzn = 1;
      end
      4'd11: begin
        if (ub >= W) begin lo = '0; c = 0; end
        else if (ub == 0) begin lo = a; c = 0; end
        else begin r = ua >> ub; lo = r[W-1:0]; r = (ua >> (ub - 1)) & 1; c = r[0]; end
        v = 0; setzn = 1;
      end
      4'd12: c = 1;
      4'd13: c = 0;
      4'd14: begin
        r = ua * ub; lo = r[W-1:0]; hi = r[2*W-1:W];
        z = (r == 0); n = hi[W-1]; c = (hi != 0); v = c;
      end
      4'd15: begin
        if (ub == 0) begin lo = '1; hi = a; v = 1; z = 0; n = 0; c = 0; end
        else begin
          r = ua / ub; lo = r[W-1:0]; r = ua % ub; hi = r[W-1:0];
          z = (lo == 0); n = 0; c = 0; v = 0;
        end
      end
      default: ;
    endcase
    if (setzn) begin z = (lo == 0); n = lo[W-1]; end
    fo = {v, z, n, c};
  endfunction

  // driver: issue one op, time its latency, optionally hold DONE, then retire it
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [W-1:0]    elo, ehi;
    logic [3:0]      ef;
    logic [SB_W-1:0] e;
    int              elat, g, lat;
    logic            got;
    ref_model(op, a, b, model_flags, elo, ehi, ef);
    elat = (op == 4'd14 || (op == 4'd15 && b != '0)) ? W + 1 : 1;
    exp_q.push_back({ef, ehi, elo, 8'(elat)});
    g = 0;
    while (in_ready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    test_cnt++;
    if (in_ready !== 1'b1) begin
      $display("FAIL ready_wait op=%0d: in_ready=%b required 1", op, in_ready);
      fail_cnt++; void'(exp_q.pop_back()); return;
    end
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk);
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk); in_valid = 1'b0; lat++;
      if (out_valid === 1'b1) got = 1'b1;
    end
    test_cnt++;
    if (!got) begin
      $display("FAIL result_timeout op=%0d: out_valid never seen, required within %0d cycles", op, elat);
      fail_cnt++; void'(exp_q.pop_front()); return;
    end
    e = exp_q.pop_front();
    obs_lo = result_lo; obs_hi = result_hi; obs_flags = flags; obs_lat = lat;
    test_cnt++;
    if (result_lo !== e[W+7:8]) begin
      $display("FAIL lo op=%0d a=%h b=%h: got %h required %h", op, a, b, result_lo, e[W+7:8]); fail_cnt++; end
    test_cnt++;
    if (result_hi !== e[2*W+7:W+8]) begin
      $display("FAIL hi op=%0d a=%h b=%h: got %h required %h", op, a, b, result_hi, e[2*W+7:W+8]); fail_cnt++; end
    test_cnt++;
    if (flags !== e[SB_W-1:SB_W-4]) begin
      $display("FAIL flags op=%0d a=%h b=%h: got %b required %b", op, a, b, flags, e[SB_W-1:SB_W-4]); fail_cnt++; end
    test_cnt++;
    if (lat !== int'(e[7:0])) begin
      $display("FAIL latency op=%0d: got %0d required %0d", op, lat, e[7:0]); fail_cnt++; end
    model_flags = ef;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1; in_op = 4'(k % 14); in_a = 16'($urandom); in_b = 16'($urandom);
      @(negedge clk);
      test_cnt++;
      if (result_lo !== obs_lo || result_hi !== obs_hi || flags !== obs_flags || out_valid !== 1'b1 ||
          in_ready !== 1'b0 || dbg_state !== ST_DONE) begin
        $display("FAIL hold cycle %0d: lo=%h hi=%h fl=%b ov=%b ir=%b required lo=%h hi=%h fl=%b ov=1 ir=0",
                 k, result_lo, result_hi, flags, out_valid, in_ready, obs_lo, obs_hi, obs_flags);
        fail_cnt++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    test_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL retire op=%0d: in_ready=%b out_valid=%b required 1/0", op, in_ready, out_valid);
      fail_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    #22;
    test_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result_lo !== '0 || result_hi !== '0 || flags !== TB_FLAG_RST) begin
      $display("FAIL reset_state: ir=%b ov=%b lo=%h hi=%h fl=%b required 1 0 0000 0000 %b",
               in_ready, out_valid, result_lo, result_hi, flags, TB_FLAG_RST);
      fail_cnt++;
    end
    @(negedge clk); rst_n = 1'b1;
    model_flags = TB_FLAG_RST;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op(4'd6, 16'h7FFF, 16'h0001, 0);
    test_cnt++;
    if (obs_lo !== 16'h8000 || obs_flags !== 4'b1010 || obs_lat !== 1) begin
      $display("FAIL add_overflow: lo=%h fl=%b lat=%0d required 8000 1010 1", obs_lo, obs_flags, obs_lat); fail_cnt++; end
    run_op(4'd7, 16'd3, 16'd5, 0);
    test_cnt++;
    if (obs_lo !== 16'hFFFE || obs_flags[0] !== 1'b1 || obs_flags[1] !== 1'b1 || obs_flags[3] !== 1'b0) begin
      $display("FAIL sub_borrow: lo=%h fl=%b required FFFE C=1 N=1 V=0", obs_lo, obs_flags); fail_cnt++; end
    run_op(4'd10, 16'h8001, 16'd1, 0);
    test_cnt++;
    if (obs_lo !== 16'h0002 || obs_flags[0] !== 1'b1) begin
      $display("FAIL shl_carry: lo=%h C=%b required 0002 1", obs_lo, obs_flags[0]); fail_cnt++; end
    run_op(4'd14, 16'hFFFF, 16'hFFFF, 0);
    test_cnt++;
    if (obs_hi !== 16'hFFFE || obs_lo !== 16'h0001 || obs_flags[0] !== 1'b1 || obs_flags[3] !== 1'b1 || obs_lat !== 17) begin
      $display("FAIL mul_max: hi=%h lo=%h fl=%b lat=%0d required FFFE 0001 C=V=1 17", obs_hi, obs_lo, obs_flags, obs_lat); fail_cnt++; end
    run_op(4'd15, 16'd100, 16'd7, 0);
    test_cnt++;
    if (obs_lo !== 16'd14 || obs_hi !== 16'd2 || obs_lat !== 17) begin
      $display("FAIL div_100_7: lo=%0d hi=%0d lat=%0d required 14 2 17", obs_lo, obs_hi, obs_lat); fail_cnt++; end
    run_op(4'd15, 16'd9, 16'd0, 0);
    test_cnt++;
    if (obs_lo !== 16'hFFFF || obs_hi !== 16'd9 || obs_flags !== 4'b1000 || obs_lat !== 1) begin
      $display("FAIL div_zero: lo=%h hi=%h fl=%b lat=%0d required FFFF 0009 1000 1", obs_lo, obs_hi, obs_flags, obs_lat); fail_cnt++; end
    run_op(4'd11, 16'h8001, 16'd0, 0);
    run_op(4'd11, 16'h8001, 16'd16, 0);
    run_op(4'd10, 16'hFFFF, 16'd15, 0);
    run_op(4'd12, 16'h1234, 16'h5678, 0);
    run_op(4'd2, 16'h1234, 16'h5678, 0);
    run_op(4'd5, 16'h8000, 16'h0000, 0);
    run_op(4'd4, 16'hFFFF, 16'h0000, 0);
    run_op(4'd14, 16'h0000, 16'h1234, 0);
  endtask

  task automatic test_hold();
    run_op(4'd6, 16'h1111, 16'h2222, 5);
    run_op(4'd14, 16'h0123, 16'h0456, 3);
  endtask

  task automatic test_reset_mid_mul();
    int g;
    logic seen;
    g = 0;
    while (in_ready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    in_op = 4'd14; in_a = 16'hFFFF; in_b = 16'hFFFF; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    test_cnt++;
    if (out_valid !== 1'b0 || flags !== TB_FLAG_RST || result_lo !== '0 || result_hi !== '0 || in_ready !== 1'b1) begin
      $display("FAIL reset_mid_mul: ov=%b fl=%b lo=%h hi=%h ir=%b required 0 %b 0000 0000 1",
               out_valid, flags, result_lo, result_hi, in_ready, TB_FLAG_RST);
      fail_cnt++;
    end
    @(negedge clk); rst_n = 1'b1;
    model_flags = TB_FLAG_RST;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
    end
    test_cnt++;
    if (seen) begin
      $display("FAIL abort_no_result: partial result or busy seen after reset, required idle"); fail_cnt++; end
    run_op(4'd6, 16'd2, 16'd2, 0);
    test_cnt++;
    if (obs_lo !== 16'd4) begin
      $display("FAIL add_after_reset: lo=%h required 0004", obs_lo); fail_cnt++; end
  endtask

  task automatic test_random();
    logic [3:0]   op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if (op == 4'd10 || op == 4'd11) b = 16'($urandom_range(0, 20));
      if (op == 4'd15 && $urandom_range(0, 4) == 0) b = '0;
      if (op == 4'd15 && $urandom_range(0, 2) == 0) b = 16'($urandom_range(1, 300));
      if ((op == 4'd4 || op == 4'd5) && $urandom_range(0, 2) == 0) a = ($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000;
      run_op(op, a, b, 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid_mul();
    test_random();
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
